// File: rtl/sd_dat_block_reader_if.sv
// Avalon-MM register port plus the SD DAT pins of the block reader.
interface sd_dat_block_reader_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        sd_clk;
  logic [3:0]  sd_dat;

  modport slave (
    input  address, chipselect, read_n, write_n, writedata, sd_dat,
    output readdata, sd_clk
  );
  modport master (
    output address, chipselect, read_n, write_n, writedata, sd_dat,
    input  readdata, sd_clk
  );
endinterface

// File: rtl/sd_dat_block_reader.sv
// SD 4-bit DAT block receiver: clocks the card, captures one block, checks the
// per-line CRC16 and the end bit, then buffers the words for CPU pops.
module sd_dat_crc_lane (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic data_en,
  input  logic crc_en,
  input  logic bit_in,
  output logic crc_ok
);
  logic [15:0] crc, rx;
  logic        fb;

  assign fb     = crc[15] ^ bit_in;
  assign crc_ok = (crc == rx);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      crc <= '0;
      rx  <= '0;
    end else begin
      if (data_en) crc <= {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      if (crc_en)  rx  <= {rx[14:0], bit_in};
    end
  end
endmodule

module sd_dat_block_reader #(
  parameter int BLOCK_BYTES = 512,
  parameter int CLK_DIV     = 2,
  parameter int TIMEOUT_DEF = 65535
) (
  input logic            clk,
  input logic            reset,
  sd_dat_block_reader_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int WORDS     = BLOCK_BYTES / 4;
  localparam int AW        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW        = $clog2(WORDS + 1);
  localparam int NIBS      = 2 * BLOCK_BYTES;
  localparam int NW        = ($clog2(NIBS) < 4) ? 4 : $clog2(NIBS);
  localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CRC  = 3'd3;
  localparam logic [2:0] S_END  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]      state;
  logic            sd_clk_q;
  logic [DW-1:0]   div_cnt;
  logic            done, crc_err, end_err, tmo_flag;
  logic [15:0]     tmo_reg, tmo_cnt;
  logic [NW-1:0]   nib_cnt;
  logic [3:0]      hi_nib;
  logic [31:0]     word;
  logic [31:0]     mem [WORDS];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     readdata_q;
  logic [NUM_LANES-1:0] crc_ok;

  logic busy, tick, rise, wr_en, rd_en, start, data_en, crc_en, buf_we;
  logic [1:0] byte_idx;
  logic [7:0] cur_byte;
  logic       unused_wdata;

  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign tick     = (div_cnt == DW'(CLK_DIV - 1));
  assign rise     = busy && tick && !sd_clk_q;
  assign wr_en    = bus.chipselect && !bus.write_n;
  assign rd_en    = bus.chipselect && !bus.read_n;
  assign start    = wr_en && (bus.address == 2'd0) && bus.writedata[0] && !busy;
  assign data_en  = rise && (state == S_DATA);
  assign crc_en   = rise && (state == S_CRC);
  assign byte_idx = nib_cnt[2:1];
  assign cur_byte = {hi_nib, bus.sd_dat};
  assign buf_we   = data_en && nib_cnt[0] && (byte_idx == 2'd3);
  assign unused_wdata = ^bus.writedata[31:16];

  assign bus.sd_clk   = sd_clk_q;
  assign bus.readdata = readdata_q;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      sd_dat_crc_lane u_lane (
        .clk(clk), .reset(reset), .clr(start),
        .data_en(data_en), .crc_en(crc_en),
        .bit_in(bus.sd_dat[g]), .crc_ok(crc_ok[g])
      );
    end
  endgenerate

  // Divider runs only while busy; dropping busy parks sd_clk low.
  always_ff @(posedge clk) begin
    if (reset || !busy) begin
      div_cnt  <= '0;
      sd_clk_q <= 1'b0;
    end else if (tick) begin
      div_cnt  <= '0;
      sd_clk_q <= !sd_clk_q;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) mem[wr_ptr[AW-1:0]] <= {cur_byte, word[23:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      done       <= 1'b0;
      crc_err    <= 1'b0;
      end_err    <= 1'b0;
      tmo_flag   <= 1'b0;
      tmo_reg    <= 16'(TIMEOUT_DEF);
      tmo_cnt    <= '0;
      nib_cnt    <= '0;
      hi_nib     <= '0;
      word       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      readdata_q <= '0;
    end else begin
      case (state)
        S_WAIT: if (rise) begin
          if (bus.sd_dat == 4'b0000) begin
            state   <= S_DATA;
            nib_cnt <= '0;
          end else if (tmo_cnt <= 16'd1) begin
            tmo_flag <= 1'b1;
            state    <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        S_DATA: if (rise) begin
          nib_cnt <= nib_cnt + 1'b1;
          if (!nib_cnt[0]) hi_nib <= bus.sd_dat;
          else             word[byte_idx*8 +: 8] <= cur_byte;
          if (nib_cnt == NW'(NIBS - 1)) begin
            state   <= S_CRC;
            nib_cnt <= '0;
          end
        end
        S_CRC: if (rise) begin
          nib_cnt <= nib_cnt + 1'b1;
          if (nib_cnt == NW'(15)) state <= S_END;
        end
        S_END: if (rise) begin
          end_err <= (bus.sd_dat != 4'hF);
          crc_err <= !(&crc_ok);
          state   <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (buf_we) wr_ptr <= wr_ptr + 1'b1;

      if (wr_en && bus.address == 2'd2) tmo_reg <= bus.writedata[15:0];

      if (rd_en) begin
        case (bus.address)
          2'd0: readdata_q <= {27'd0, tmo_flag, end_err, crc_err, done, busy};
          2'd1: begin
            if (rd_ptr != wr_ptr) begin
              readdata_q <= mem[rd_ptr[AW-1:0]];
              rd_ptr     <= rd_ptr + 1'b1;
            end else begin
              readdata_q <= '0;
            end
          end
          2'd2:    readdata_q <= {16'd0, tmo_reg};
          default: readdata_q <= '0;
        endcase
      end

      // Start wins over everything above so a fresh transfer begins clean.
      if (start) begin
        done     <= 1'b0;
        crc_err  <= 1'b0;
        end_err  <= 1'b0;
        tmo_flag <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        tmo_cnt  <= tmo_reg;
        state    <= S_WAIT;
      end
    end
  end
endmodule

// File: tb/tb_sd_dat_block_reader.sv
// Bench: card model drives DAT nibbles; expected words/CRC/status come from a
// byte-level reference (little-endian packing, CRC by polynomial long division).
module tb_sd_dat_block_reader;
  typedef logic [3:0] nib_q_t[$];
  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        cs, rd_n, wr_n;
  logic [31:0] wdata;
  logic [3:0]  dat;
  logic        sel;
  int          n_cmp = 0;
  int          n_err = 0;
  int          last_gap = 0;

  always #5 clk = ~clk;

  sd_dat_block_reader_if ifa ();
  sd_dat_block_reader_if ifb ();

  assign ifa.address = addr;  assign ifb.address = addr;
  assign ifa.read_n = rd_n;   assign ifb.read_n = rd_n;
  assign ifa.write_n = wr_n;  assign ifb.write_n = wr_n;
  assign ifa.writedata = wdata; assign ifb.writedata = wdata;
  assign ifa.sd_dat = dat;    assign ifb.sd_dat = dat;
  assign ifa.chipselect = cs && !sel;
  assign ifb.chipselect = cs && sel;

  wire [31:0] rdata = sel ? ifb.readdata : ifa.readdata;
  wire        sclk  = sel ? ifb.sd_clk : ifa.sd_clk;

  sd_dat_block_reader #(.BLOCK_BYTES(8), .CLK_DIV(1), .TIMEOUT_DEF(65535))
    dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  sd_dat_block_reader #(.BLOCK_BYTES(512), .CLK_DIV(2), .TIMEOUT_DEF(65535))
    dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; cs = 1'b1; wr_n = 1'b0;
    @(posedge clk); #1;
    cs = 1'b0; wr_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    addr = a; cs = 1'b1; rd_n = 1'b0;
    @(posedge clk); #1;
    cs = 1'b0; rd_n = 1'b1;
    d = rdata;
  endtask

  task automatic wait_rise(output bit ok);
    logic last;
    int   n;
    last = sclk; ok = 1'b0; n = 0;
    while (!ok && n < 64) begin
      @(posedge clk); #1;
      n++;
      if (sclk && !last) ok = 1'b1;
      last = sclk;
    end
    last_gap = n;
  endtask

  // Card model: present each nibble, hold it until the DUT's sd_clk rises.
  task automatic send(input nib_q_t q, input int inj);
    bit ok;
    foreach (q[i]) begin
      dat = q[i];
      if (i == inj) bus_write(2'd0, 32'h1);
      wait_rise(ok);
      if (!ok) begin
        n_cmp++; n_err++;
        $display("FAIL sd_clk_rise: no rise within 64 cycles at nibble %0d, required a rise", i);
        dat = 4'hF;
        return;
      end
    end
    dat = 4'hF;
  endtask

  function automatic logic [15:0] line_crc(input byte_q_t d, input int line);
    logic [16:0] rem;
    logic        b;
    rem = '0;
    for (int i = 0; i < d.size() * 2 + 16; i++) begin
      if (i < d.size() * 2) b = (i % 2 == 0) ? d[i/2][4+line] : d[i/2][line];
      else                  b = 1'b0;
      rem = {rem[15:0], b};
      if (rem[16]) rem = rem ^ 17'h11021;
    end
    return rem[15:0];
  endfunction

  task automatic run_block(input string name, input byte_q_t d, input int pre,
                           input logic [3:0] pre_nib, input int flip_line,
                           input int flip_bit, input bit end_bad, input int inj);
    nib_q_t      q;
    logic [15:0] c [4];
    logic [31:0] got, exp_w;
    logic [31:0] exp_st;
    int          inj_idx;
    for (int l = 0; l < 4; l++) c[l] = line_crc(d, l);
    if (flip_line >= 0) c[flip_line][flip_bit] = ~c[flip_line][flip_bit];
    for (int i = 0; i < pre; i++) q.push_back(pre_nib);
    q.push_back(4'h0);
    foreach (d[i]) begin q.push_back(d[i][7:4]); q.push_back(d[i][3:0]); end
    for (int j = 15; j >= 0; j--) q.push_back({c[3][j], c[2][j], c[1][j], c[0][j]});
    q.push_back(end_bad ? 4'hE : 4'hF);
    inj_idx = (inj >= 0) ? pre + 1 + inj : -1;
    bus_write(2'd0, 32'h1);
    send(q, inj_idx);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (sclk !== 1'b0) begin
      n_err++; $display("FAIL %s_sdclk_idle: got %b, required 0", name, sclk);
    end
    exp_st = 32'h2 | ((flip_line >= 0) ? 32'h4 : 32'h0) | (end_bad ? 32'h8 : 32'h0);
    bus_read(2'd0, got);
    n_cmp++;
    if (got !== exp_st) begin
      n_err++; $display("FAIL %s_status: got %h, required %h", name, got, exp_st);
    end
    for (int k = 0; k < d.size() / 4; k++) begin
      exp_w = {d[4*k+3], d[4*k+2], d[4*k+1], d[4*k]};
      bus_read(2'd1, got);
      n_cmp++;
      if (got !== exp_w) begin
        n_err++; $display("FAIL %s_word%0d: got %h, required %h", name, k, got, exp_w);
      end
    end
    bus_read(2'd1, got);
    n_cmp++;
    if (got !== 32'h0) begin
      n_err++; $display("FAIL %s_empty_pop: got %h, required 0", name, got);
    end
  endtask

  task automatic test_reset;
    logic [31:0] got;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    n_cmp++;
    if (rdata !== 32'h0 || sclk !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs: got readdata %h sd_clk %b, required 0/0", rdata, sclk);
    end
    bus_read(2'd0, got); n_cmp++;
    if (got !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h, required 0", got); end
    bus_read(2'd2, got); n_cmp++;
    if (got !== 32'h0000FFFF) begin n_err++; $display("FAIL reset_timeout_reg: got %h, required 0000ffff", got); end
    bus_read(2'd1, got); n_cmp++;
    if (got !== 32'h0) begin n_err++; $display("FAIL reset_pop: got %h, required 0", got); end
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, got); n_cmp++;
    if (got !== 32'h0) begin n_err++; $display("FAIL addr3_read: got %h, required 0", got); end
  endtask

  task automatic test_basic;
    byte_q_t d;
    for (int i = 0; i < 8; i++) d.push_back(8'((2*i) << 4 | (2*i + 1)));
    run_block("basic", d, 3, 4'hF, -1, 0, 1'b0, -1);
  endtask

  task automatic test_crc_err;
    byte_q_t d;
    for (int i = 0; i < 8; i++) d.push_back(8'((2*i) << 4 | (2*i + 1)));
    run_block("crc_err", d, 3, 4'hF, 2, 7, 1'b0, -1);
  endtask

  task automatic test_end_err;
    byte_q_t d;
    for (int i = 0; i < 8; i++) d.push_back(8'((2*i) << 4 | (2*i + 1)));
    run_block("end_err", d, 3, 4'hF, -1, 0, 1'b1, -1);
  endtask

  task automatic test_timeout;
    logic [31:0] got;
    bit ok;
    int extra;
    dat = 4'hF;
    bus_write(2'd2, 32'h5);
    bus_write(2'd0, 32'h1);
    for (int i = 0; i < 4; i++) wait_rise(ok);
    bus_read(2'd0, got); n_cmp++;
    if (got !== 32'h1) begin n_err++; $display("FAIL timeout_busy_after4: got %h, required 1", got); end
    wait_rise(ok); n_cmp++;
    if (!ok) begin n_err++; $display("FAIL timeout_rise5: no 5th rise, required one"); end
    repeat (2) @(posedge clk);
    #1; n_cmp++;
    if (sclk !== 1'b0) begin n_err++; $display("FAIL timeout_sdclk: got %b, required 0", sclk); end
    bus_read(2'd0, got); n_cmp++;
    if (got !== 32'h12) begin n_err++; $display("FAIL timeout_status: got %h, required 12", got); end
    bus_read(2'd1, got); n_cmp++;
    if (got !== 32'h0) begin n_err++; $display("FAIL timeout_pop: got %h, required 0", got); end
    extra = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (sclk) extra++; end
    n_cmp++;
    if (extra != 0) begin n_err++; $display("FAIL timeout_no_more_clk: got %0d high cycles, required 0", extra); end
    bus_write(2'd2, 32'hFFFF);
  endtask

  task automatic test_start_reset;
    nib_q_t      q;
    logic [31:0] got;
    q = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    bus_write(2'd0, 32'h1);
    send(q, 5);
    bus_read(2'd0, got); n_cmp++;
    if (got !== 32'h1) begin n_err++; $display("FAIL midxfer_status: got %h, required 1", got); end
    dat = 4'h6;
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (rdata !== 32'h0 || sclk !== 1'b0) begin
      n_err++; $display("FAIL abort_outputs: got readdata %h sd_clk %b, required 0/0", rdata, sclk);
    end
    @(posedge clk); #1;
    reset = 1'b0; dat = 4'hF;
    bus_read(2'd0, got); n_cmp++;
    if (got !== 32'h0) begin n_err++; $display("FAIL abort_status: got %h, required 0", got); end
    bus_read(2'd1, got); n_cmp++;
    if (got !== 32'h0) begin n_err++; $display("FAIL abort_pop: got %h, required 0", got); end
  endtask

  task automatic test_back_to_back;
    byte_q_t d;
    int fl, fb, inj;
    bit eb;
    for (int it = 0; it < 6; it++) begin
      d.delete();
      for (int i = 0; i < 8; i++) d.push_back(8'($urandom_range(0, 255)));
      fl  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
      fb  = int'($urandom_range(0, 15));
      eb  = ($urandom_range(0, 3) == 0);
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
      run_block($sformatf("rand%0d", it), d, int'($urandom_range(0, 4)),
                4'($urandom_range(1, 15)), fl, fb, eb, inj);
    end
  endtask

  task automatic test_big_zero;
    byte_q_t d;
    sel = 1'b1;
    for (int i = 0; i < 512; i++) d.push_back(8'h00);
    run_block("big_zero", d, 3, 4'hF, -1, 0, 1'b0, -1);
    n_cmp++;
    if (last_gap != 4) begin n_err++; $display("FAIL big_sdclk_period: got %0d clk, required 4", last_gap); end
    sel = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = '0; cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
    wdata = '0; dat = 4'hF; sel = 1'b0;
    test_reset();
    test_basic();
    test_crc_err();
    test_end_err();
    test_timeout();
    test_start_reset();
    test_back_to_back();
    test_big_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sd_dat_block_reader.md
Name: sd_dat_block_reader

Overview:
- Hardware receiver for SD 4-bit DAT bus read transfers.
- Generates the SD clock, waits for the start bit and captures one data block nibble-wise. Checks the per-line CRC16 and the end bit, then buffers the block for word reads by the CPU.
- Sits beside the bit-banged SD CMD/DAT PIO slaves on the Avalon fabric and replaces CPU polling of DAT for block reads.

Parameters:
- BLOCK_BYTES, 512: bytes per block; must be a multiple of 4, minimum 4.
- CLK_DIV, 2: clk cycles per sd_clk half-period; minimum 1.
- TIMEOUT_DEF, 65535: reset value of the start-bit timeout, counted in sd_clk periods.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  2  Avalon register select
- chipselect  in  1  Avalon chip select
- read_n  in  1  Avalon read strobe, active low
- write_n  in  1  Avalon write strobe, active low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- sd_clk  out  1  SD clock to card
- sd_dat  in  4  SD DAT[3:0]; top level keeps the pads tristated while this block owns them

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Reset values: readdata=0, sd_clk=0, state=IDLE, status flags=0, buffer pointers=0, timeout register=TIMEOUT_DEF.
- Register map: every access qualifies on chipselect.
  - Addr 0 write: bit0=1 starts a transfer; ignored when busy.
  - Addr 0 read: bit0 busy, bit1 done, bit2 crc_err, bit3 end_err, bit4 timeout; other bits 0.
  - Addr 1 read: pops one buffered word. Byte order is little-endian: first received byte is in [7:0].
  - Addr 1 read with buffer empty: returns 0, pointers unchanged.
  - Addr 2: timeout reload, bits [15:0], read/write.
  - Addr 3: reads 0, writes ignored.
- Read latency: readdata is registered, so it is valid one cycle after the read. The pop takes effect in that same cycle.
- SD clock:
  - A divider toggles sd_clk every CLK_DIV clk cycles only while busy.
  - Idle level is low.
  - sd_dat is sampled in the clk cycle where sd_clk goes 0 to 1 (the "rise strobe").
  - Leaving busy forces sd_clk low on the next cycle.
- Start: clears done, crc_err, end_err, timeout and both buffer pointers. Loads the timeout counter, sets busy and enters WAIT_START.
- WAIT_START:
  - On each rise strobe: if sd_dat==4'b0000, go to DATA.
  - Otherwise decrement the counter; when it reaches 0, set timeout and go to DONE.
- DATA: receives 2*BLOCK_BYTES nibbles, one per rise strobe.
  - The first nibble of each byte is the high nibble; DAT3 carries the MSB.
  - Bytes assemble into a 32-bit word, which is written to the buffer after its 4th byte.
  - The CRC16 of each line updates in parallel: polynomial x^16+x^12+x^5+1, init 0, MSB-first.
  - After the last nibble, go to CRC.
- CRC: captures 16 bits per line, MSB first, into shift registers over 16 strobes, then goes to END.
- END:
  - One strobe; all four lines must read 1, otherwise set end_err.
  - Compare the computed CRC against the received CRC for each line; any mismatch sets crc_err.
  - Go to DONE.
- DONE: set done, clear busy, go to IDLE the next cycle. Flags hold until the next start.
- Buffer: BLOCK_BYTES/4 words, single clock. Write and pop may occur in the same cycle; a pop can return a word written in an earlier cycle.
- Start during busy: no effect.
- Reset mid-transfer: abort immediately, all reset values apply, buffer is empty.

Test Plan:
1. BLOCK_BYTES=8, CLK_DIV=1: write addr0=1; model drives 1111 for 3 sd_clk, start 0000, then nibbles 0,1,2,3,...,F, CRC16=correct per line, end 1111. Required: addr0 reads 0x02; addr1 reads 0x67452301 then 0xEFCDAB89; a 3rd read returns 0.
2. Same as 1 with bit 7 of the DAT2 CRC inverted. Required: status 0x06; data words still correct.
3. Same as 1 with DAT0=0 at the end bit. Required: status 0x0A.
4. Timeout reg=5, DAT held 1111. Required: after exactly 5 sd_clk rises, status 0x12 and sd_clk low; addr1 reads 0.
5. Start during DATA phase, then reset asserted at nibble 6. Required: the second start has no effect; after reset, status=0, readdata=0, sd_clk=0 and the buffer is empty.
6. All-zero data block with CRC 0x0000 on all lines, BLOCK_BYTES=512, CLK_DIV=2. Required: status 0x02; 128 reads of 0; sd_clk period is 4 clk.
